// File: rtl/cmd_sequencer_if.sv
// FIFO read handshake between the command sequencer and its upstream byte FIFO.
// The sequencer issues single-cycle read strobes; the FIFO returns the byte
// one cycle after each strobe.
interface cmd_sequencer_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd;

    // Sequencer side: watches the flag and data, drives the read strobe.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd
    );

    // FIFO side: supplies the flag and data, receives the read strobe.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd
    );
endinterface : cmd_sequencer_if

// File: rtl/cmd_sequencer.sv
// Keyboard-style command sequencer. It pulls one byte at a time from an
// upstream FIFO and decodes w/a/s/d (move, with wrap-around) and r
// (recenter), case-insensitively. Unknown bytes raise a one-cycle err pulse.
// After every accepted move a cooldown of HOLDOFF cycles blocks further reads.
module cmd_sequencer #(
    parameter int X_MAX   = 4,
    parameter int Y_MAX   = 4,
    parameter int X_INIT  = 2,
    parameter int Y_INIT  = 4,
    parameter int HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    cmd_sequencer_if.master   fifo,
    output logic [7:0]        x,
    output logic [7:0]        y,
    output logic              move,
    output logic              err,
    output logic [7:0]        last_key,
    output logic              busy
);

    // A zero-cycle holdoff still needs a legal (1-bit) counter.
    localparam int CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [7:0] X_MAX_B  = 8'(X_MAX);
    localparam logic [7:0] Y_MAX_B  = 8'(Y_MAX);
    localparam logic [7:0] X_INIT_B = 8'(X_INIT);
    localparam logic [7:0] Y_INIT_B = 8'(Y_INIT);

    localparam logic [7:0] KEY_W = 8'h77;
    localparam logic [7:0] KEY_S = 8'h73;
    localparam logic [7:0] KEY_A = 8'h61;
    localparam logic [7:0] KEY_D = 8'h64;
    localparam logic [7:0] KEY_R = 8'h72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXEC,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         x_q, x_d;
    logic [7:0]         y_q, y_d;
    logic [7:0]         last_key_q, last_key_d;
    logic               move_q, move_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         key_ci;
    logic               key_hit;
    logic [1:0]         rst_sync_q;
    logic               rst_n;

    // Reset synchroniser: assertion reaches the logic at once, release is aligned to clk.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // State, coordinate, key and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= X_INIT_B;
            y_q        <= Y_INIT_B;
            last_key_q <= 8'h00;
            move_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            last_key_q <= last_key_d;
            move_q     <= move_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: read strobe, key capture, decode and holdoff countdown.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        last_key_d   = last_key_q;
        move_d       = 1'b0;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        fifo.fifo_rd = 1'b0;
        key_hit      = 1'b0;
        key_ci       = last_key_q | 8'h20;   // fold upper case onto lower case

        unique case (state_q)
            ST_IDLE: begin
                if (enable && !fifo.fifo_empty) begin
                    fifo.fifo_rd = 1'b1;
                    state_d      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                last_key_d = fifo.fifo_dout;
                state_d    = ST_EXEC;
            end

            ST_EXEC: begin
                key_hit = 1'b1;
                case (key_ci)
                    KEY_W:   y_d = (y_q == 8'd0)    ? Y_MAX_B : y_q - 8'd1;
                    KEY_S:   y_d = (y_q == Y_MAX_B) ? 8'd0    : y_q + 8'd1;
                    KEY_A:   x_d = (x_q == 8'd0)    ? X_MAX_B : x_q - 8'd1;
                    KEY_D:   x_d = (x_q == X_MAX_B) ? 8'd0    : x_q + 8'd1;
                    KEY_R: begin
                        x_d = X_INIT_B;
                        y_d = Y_INIT_B;
                    end
                    default: key_hit = 1'b0;
                endcase

                if (key_hit) begin
                    move_d = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLDOFF);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_HOLD: begin
                // The cycle that sees a count of 1 is the last holdoff cycle.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign x        = x_q;
    assign y        = y_q;
    assign move     = move_q;
    assign err      = err_q;
    assign last_key = last_key_q;
    assign busy     = (state_q != ST_IDLE);

endmodule : cmd_sequencer

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with default parameters
// (X_MAX=4, Y_MAX=4, X_INIT=2, Y_INIT=4, HOLDOFF=16).
// A decode table is run back to back, followed by hand-written sequences for
// read spacing, enable gating and reset in the middle of a transfer.
module tb_cmd_sequencer;

    localparam int RD_BUDGET   = 60;
    localparam int IDLE_BUDGET = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] x;
    logic [7:0] y;
    logic       move;
    logic       err;
    logic [7:0] last_key;
    logic       busy;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    cmd_sequencer_if fifo_bus ();

    cmd_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .fifo     (fifo_bus.master),
        .x        (x),
        .y        (y),
        .move     (move),
        .err      (err),
        .last_key (last_key),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Free-running cycle index used to timestamp read strobes.
    always @(posedge clk) cyc++;

    typedef struct {
        string      name;
        logic [7:0] key;
        logic [7:0] exp_x;
        logic [7:0] exp_y;
        logic       exp_move;
        logic       exp_err;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Starts just after a falling edge; polls fifo_rd once per cycle.
    task automatic wait_rd(output int rd_cycle);
        bit seen;
        seen     = 1'b0;
        rd_cycle = -1;
        for (int i = 0; i < RD_BUDGET && !seen; i++) begin
            #1;
            if (fifo_bus.fifo_rd === 1'b1) begin
                seen     = 1'b1;
                rd_cycle = cyc;
            end else begin
                @(negedge clk);
            end
        end
        check("fifo_rd_seen", 32'(fifo_bus.fifo_rd), 32'd1);
    endtask

    // Queues one byte, waits for its read (cycle N), then returns in cycle N+3.
    task automatic push_and_run(input logic [7:0] key, output int rd_cycle);
        fifo_bus.fifo_dout  = key;
        fifo_bus.fifo_empty = 1'b0;
        wait_rd(rd_cycle);
        @(negedge clk);                 // cycle N+1
        fifo_bus.fifo_empty = 1'b1;
        #1;
        check("no_rd_in_wait", 32'(fifo_bus.fifo_rd), 32'd0);
        repeat (2) @(negedge clk);      // cycle N+3
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < IDLE_BUDGET && busy !== 1'b0; i++) begin
            @(negedge clk);
            #1;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_a;
        int rd_b;
        int rd_count;
        int move_count;

        vecs[0]  = '{"d_inc",       8'h64, 8'd3, 8'd4, 1'b1, 1'b0};
        vecs[1]  = '{"d_to_max",    8'h64, 8'd4, 8'd4, 1'b1, 1'b0};
        vecs[2]  = '{"D_wrap",      8'h44, 8'd0, 8'd4, 1'b1, 1'b0};
        vecs[3]  = '{"a_wrap",      8'h61, 8'd4, 8'd4, 1'b1, 1'b0};
        vecs[4]  = '{"A_dec",       8'h41, 8'd3, 8'd4, 1'b1, 1'b0};
        vecs[5]  = '{"w_dec",       8'h77, 8'd3, 8'd3, 1'b1, 1'b0};
        vecs[6]  = '{"W_dec",       8'h57, 8'd3, 8'd2, 1'b1, 1'b0};
        vecs[7]  = '{"w_dec2",      8'h77, 8'd3, 8'd1, 1'b1, 1'b0};
        vecs[8]  = '{"w_to_zero",   8'h77, 8'd3, 8'd0, 1'b1, 1'b0};
        vecs[9]  = '{"w_wrap",      8'h77, 8'd3, 8'd4, 1'b1, 1'b0};
        vecs[10] = '{"s_wrap",      8'h73, 8'd3, 8'd0, 1'b1, 1'b0};
        vecs[11] = '{"S_inc",       8'h53, 8'd3, 8'd1, 1'b1, 1'b0};
        vecs[12] = '{"bad_0x35",    8'h35, 8'd3, 8'd1, 1'b0, 1'b1};
        vecs[13] = '{"r_center",    8'h72, 8'd2, 8'd4, 1'b1, 1'b0};
        vecs[14] = '{"R_centered",  8'h52, 8'd2, 8'd4, 1'b1, 1'b0};
        vecs[15] = '{"bad_0x00",    8'h00, 8'd2, 8'd4, 1'b0, 1'b1};
        vecs[16] = '{"bad_q",       8'h71, 8'd2, 8'd4, 1'b0, 1'b1};

        reset               = 1'b0;
        enable              = 1'b1;
        fifo_bus.fifo_empty = 1'b1;
        fifo_bus.fifo_dout  = 8'h00;

        // Values while reset is held.
        repeat (2) @(negedge clk);
        #1;
        check("rst_x",        32'(x),                 32'd2);
        check("rst_y",        32'(y),                 32'd4);
        check("rst_last_key", 32'(last_key),          32'd0);
        check("rst_move",     32'(move),              32'd0);
        check("rst_err",      32'(err),               32'd0);
        check("rst_busy",     32'(busy),              32'd0);
        check("rst_fifo_rd",  32'(fifo_bus.fifo_rd),  32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Decode table, applied back to back from the reset position.
        for (int i = 0; i < 17; i++) begin
            push_and_run(vecs[i].key, rd_a);
            check({vecs[i].name, "_x"},        32'(x),        32'(vecs[i].exp_x));
            check({vecs[i].name, "_y"},        32'(y),        32'(vecs[i].exp_y));
            check({vecs[i].name, "_move"},     32'(move),     32'(vecs[i].exp_move));
            check({vecs[i].name, "_err"},      32'(err),      32'(vecs[i].exp_err));
            check({vecs[i].name, "_last_key"}, 32'(last_key), 32'(vecs[i].key));
            @(negedge clk);
            #1;
            check({vecs[i].name, "_pulse_end"}, 32'({move, err}), 32'd0);
            wait_idle();
        end

        // Two 'a' bytes back to back: second read exactly N+3+HOLDOFF.
        do_reset();
        push_and_run(8'h61, rd_a);
        check("aa_first_x", 32'(x), 32'd1);
        check("aa_first_move", 32'(move), 32'd1);
        check("aa_hold_busy", 32'(busy), 32'd1);
        push_and_run(8'h61, rd_b);
        check("aa_rd_spacing", 32'(rd_b - rd_a), 32'd19);
        check("aa_second_x", 32'(x), 32'd0);
        wait_idle();

        // Unknown byte: no holdoff, next read in N+3.
        push_and_run(8'h35, rd_a);
        check("bad_err", 32'(err), 32'd1);
        check("bad_x", 32'(x), 32'd0);
        check("bad_last_key", 32'(last_key), 32'h35);
        push_and_run(8'h64, rd_b);
        check("bad_rd_spacing", 32'(rd_b - rd_a), 32'd3);
        check("bad_then_d_x", 32'(x), 32'd1);
        wait_idle();

        // enable=0 with a non-empty FIFO: no read, not busy.
        enable              = 1'b0;
        fifo_bus.fifo_dout  = 8'h64;
        fifo_bus.fifo_empty = 1'b0;
        rd_count            = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (fifo_bus.fifo_rd === 1'b1) rd_count++;
            @(negedge clk);
        end
        check("dis_rd_count", 32'(rd_count), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);

        // Enable dropped during HOLD: move completes, no further read.
        enable = 1'b1;
        push_and_run(8'h64, rd_a);
        enable              = 1'b0;
        fifo_bus.fifo_empty = 1'b0;
        check("hold_drop_move", 32'(move), 32'd1);
        check("hold_drop_x", 32'(x), 32'd2);
        rd_count = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            if (fifo_bus.fifo_rd === 1'b1) rd_count++;
        end
        check("hold_drop_rd_count", 32'(rd_count), 32'd0);
        check("hold_drop_busy", 32'(busy), 32'd0);
        check("hold_drop_x_after", 32'(x), 32'd2);
        enable = 1'b1;
        push_and_run(8'h61, rd_a);
        check("reenable_x", 32'(x), 32'd1);
        wait_idle();

        // Reset asserted while in WAIT: immediate return to 2/4, byte discarded.
        fifo_bus.fifo_dout  = 8'h64;
        fifo_bus.fifo_empty = 1'b0;
        wait_rd(rd_a);
        @(negedge clk);
        fifo_bus.fifo_empty = 1'b1;
        #1;
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_x_before", 32'(x), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_x", 32'(x), 32'd2);
        check("async_rst_y", 32'(y), 32'd4);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_last_key", 32'(last_key), 32'd0);
        repeat (2) @(negedge clk);
        reset      = 1'b1;
        move_count = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (move === 1'b1) move_count++;
        end
        check("post_rst_moves", 32'(move_count), 32'd0);
        check("post_rst_x", 32'(x), 32'd2);
        check("post_rst_last_key", 32'(last_key), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cmd_sequencer

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 SHALL have parameter X_MAX, default 4, meaning the largest x coordinate (x range 0..X_MAX).
REQ-002 SHALL have parameter Y_MAX, default 4, meaning the largest y coordinate (y range 0..Y_MAX).
REQ-003 SHALL have parameter X_INIT, default 2, meaning the reset and recenter x value.
REQ-004 SHALL have parameter Y_INIT, default 4, meaning the reset and recenter y value.
REQ-005 SHALL have parameter HOLDOFF, default 16, meaning the cooldown cycles after an accepted move.
REQ-006 SHALL have port clk, input, 1 bit, as the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit, as the reset, asynchronous and active-low.
REQ-008 SHALL have port enable, input, 1 bit; 1 permits new FIFO reads.
REQ-009 SHALL have port fifo_empty, input, 1 bit; the empty flag of the upstream byte FIFO.
REQ-010 SHALL have port fifo_dout, input, 8 bits; FIFO read data, valid one cycle after fifo_rd.
REQ-011 SHALL have port fifo_rd, output, 1 bit; a single-cycle FIFO read strobe.
REQ-012 SHALL have port x, output, 8 bits; the current x coordinate.
REQ-013 SHALL have port y, output, 8 bits; the current y coordinate.
REQ-014 SHALL have port move, output, 1 bit; a 1-cycle pulse when x or y was updated.
REQ-015 SHALL have port err, output, 1 bit; a 1-cycle pulse when an unrecognised byte was consumed.
REQ-016 SHALL have port last_key, output, 8 bits; the last byte consumed.
REQ-017 SHALL have port busy, output, 1 bit; 1 in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, EXEC and HOLD.
REQ-019 SHALL, in IDLE with enable=1 and fifo_empty=0, drive fifo_rd=1 combinationally for that cycle N and go to WAIT; otherwise it SHALL stay in IDLE.
REQ-020 SHALL hold fifo_rd=0 in all states other than IDLE, so at most one read is outstanding.
REQ-021 SHALL, in WAIT (cycle N+1), register fifo_dout into last_key and go to EXEC.
REQ-022 SHALL, in EXEC (cycle N+2), decode last_key case-insensitively, i.e. with bit 5 forced to 1 before compare.
REQ-023 SHALL decode 0x77 'w' as y := (y==0) ? Y_MAX : y-1.
REQ-024 SHALL decode 0x73 's' as y := (y==Y_MAX) ? 0 : y+1.
REQ-025 SHALL decode 0x61 'a' as x := (x==0) ? X_MAX : x-1.
REQ-026 SHALL decode 0x64 'd' as x := (x==X_MAX) ? 0 : x+1.
REQ-027 SHALL decode 0x72 'r' as x := X_INIT and y := Y_INIT.
REQ-028 SHALL, for a recognised key, show the new x/y and move=1 in cycle N+3, then go to HOLD, or to IDLE when HOLDOFF=0.
REQ-029 SHALL, for an unrecognised byte, leave x/y unchanged, pulse err=1 in cycle N+3 and go directly to IDLE with no holdoff.
REQ-030 SHALL assert move even when the new value equals the old one, e.g. 'r' while already centred.
REQ-031 SHALL, in HOLD, count exactly HOLDOFF cycles, then go to IDLE; the earliest next fifo_rd is cycle N+3+HOLDOFF.
REQ-032 SHALL use a HOLD counter of width $clog2(HOLDOFF+1), loaded on entry and decremented to 0.
REQ-033 SHALL, when enable falls mid-operation, let the in-flight byte complete EXEC/HOLD; only new reads are blocked.
REQ-034 SHALL let fifo_empty changes outside IDLE have no effect.
REQ-035 SHALL never assert move and err in the same cycle.
REQ-036 SHALL perform all arithmetic in 8 bits; x never exceeds X_MAX and y never exceeds Y_MAX.

Reset
REQ-037 SHALL, on reset=0 (asynchronous), immediately set state=IDLE, x=X_INIT, y=Y_INIT, last_key=0, move=0, err=0, fifo_rd=0, busy=0 and the HOLD counter to 0.
REQ-038 SHALL, on reset mid-operation, discard any byte already read; reset deassertion is synchronised to clk.

Verification
REQ-039 SHALL verify: reset, then 'd' queued -> fifo_rd at N, x=3 and move=1 at N+3, y=4.
REQ-040 SHALL verify: x=4, 'D' (0x44) -> x wraps to 0; y=0, 'w' -> y wraps to 4.
REQ-041 SHALL verify: bytes 'a','a' back-to-back with HOLDOFF=16 -> second fifo_rd no earlier than 19 cycles after the first; x 2->1->0.
REQ-042 SHALL verify: byte 0x35 -> err=1 for one cycle, x/y unchanged, last_key=0x35, next fifo_rd possible at N+3.
REQ-043 SHALL verify: enable=0 with a non-empty FIFO -> no fifo_rd and busy=0; enable dropped during HOLD -> move completes and no further read.
REQ-044 SHALL verify: reset asserted in WAIT -> outputs return to 2/4 asynchronously and the pending byte is not applied after release.
